// File: rtl/jtvigil_pcm_multi_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : jtvigil_pcm_multi_if
// Brief  : Sound-CPU I/O port, shared ROM port and sample outputs of the PCM fetcher
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface jtvigil_pcm_multi_if #(
   parameter int CH = 2,
   parameter int AW = 16,
   parameter int CW = 1
);
   logic            cpu_wr;
   logic            cpu_rd;
   logic [CW-1:0]   cpu_ch;
   logic [1:0]      cpu_reg;
   logic [7:0]      cpu_din;
   logic [7:0]      cpu_dout;
   logic            rom_cs;
   logic [AW-1:0]   rom_addr;
   logic [7:0]      rom_data;
   logic            rom_ok;
   logic [CH*8-1:0] snd;
   logic [CH-1:0]   snd_stb;
   logic            tick;

   modport master (
      output cpu_wr, cpu_rd, cpu_ch, cpu_reg, cpu_din, rom_data, rom_ok, tick,
      input  cpu_dout, rom_cs, rom_addr, snd, snd_stb
   );

   modport slave (
      input  cpu_wr, cpu_rd, cpu_ch, cpu_reg, cpu_din, rom_data, rom_ok, tick,
      output cpu_dout, rom_cs, rom_addr, snd, snd_stb
   );
endinterface
`default_nettype wire

// File: rtl/jtvigil_pcm_multi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : jtvigil_pcm_multi
// Brief  : CPU-programmed multi-channel PCM fetcher, round-robin shared ROM port.
//          Optional tick-driven autoplay with 8'hFF end marker: JTVIGIL_PCM_AUTO_EN
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module jtvigil_pcm_multi #(
   parameter int CH = 2,
   parameter int AW = 16,
   parameter int CW = 1
) (
   input wire                clk,
   input wire                rst_n,
   jtvigil_pcm_multi_if.slave bus
);
   localparam logic [1:0]    c_IDLE    = 2'd0;
   localparam logic [1:0]    c_ADDR    = 2'd1;
   localparam logic [1:0]    c_WAIT    = 2'd2;
   localparam logic [1:0]    c_DONE    = 2'd3;
   localparam logic [AW-1:0] c_LO_MASK = AW'(8'hFF);

   logic [1:0]      r_state, w_state_nxt;
   logic            r_wr_d, w_wr_rise;
   logic [CH-1:0]   w_adv, r_pend, w_clr, r_stb;
   logic [AW-1:0]   r_cnt [CH];
   logic [7:0]      r_snd [CH];
   logic [7:0]      r_shadow [CH];
   logic [CW-1:0]   r_gnt, r_last, w_next, w_sel_hi, w_sel_lo;
   logic            w_any, w_hit_hi, w_grant, w_capture, w_done, w_end;
   logic [AW-1:0]   r_addr, w_gnt_cnt;
   logic [7:0]      r_data;
   logic [CH*8-1:0] w_snd;
`ifdef JTVIGIL_PCM_AUTO_EN
   logic [CH-1:0]   r_auto;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_wr_d <= 1'b0;
      else        r_wr_d <= bus.cpu_wr;
   end
   assign w_wr_rise = bus.cpu_wr & ~r_wr_d;

   for (genvar n = 0; n < CH; n++) begin : g_adv
      logic w_cpu_adv;
      assign w_cpu_adv = w_wr_rise && (bus.cpu_ch == CW'(n)) && (bus.cpu_reg == 2'd2);
`ifdef JTVIGIL_PCM_AUTO_EN
      assign w_adv[n] = w_cpu_adv | (bus.tick & r_auto[n]);
`else
      assign w_adv[n] = w_cpu_adv;
`endif
   end

   // A new advance outranks a grant clear so an in-flight fetch is always followed by a refetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CH; k++) r_cnt[k] <= '0;
         r_pend <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (w_adv[k])
               r_cnt[k] <= r_cnt[k] + 1'b1;
            else if (w_wr_rise && bus.cpu_ch == CW'(k) && bus.cpu_reg == 2'd0)
               r_cnt[k] <= (r_cnt[k] & ~c_LO_MASK) | AW'(bus.cpu_din);
            else if (w_wr_rise && bus.cpu_ch == CW'(k) && bus.cpu_reg == 2'd1)
               r_cnt[k] <= (r_cnt[k] & c_LO_MASK) | AW'({bus.cpu_din, 8'h00});
            if (w_adv[k])      r_pend[k] <= 1'b1;
            else if (w_clr[k]) r_pend[k] <= 1'b0;
         end
      end
   end

`ifdef JTVIGIL_PCM_AUTO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_auto <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (w_done && w_end && r_gnt == CW'(k)) r_auto[k] <= 1'b0;
            if (w_wr_rise && bus.cpu_ch == CW'(k) && bus.cpu_reg == 2'd3)
               r_auto[k] <= bus.cpu_din[0];
         end
      end
   end
   assign w_end = (r_data == 8'hFF);
`else
   assign w_end = 1'b0;
`endif

   // Round robin: lowest pending channel above the last grant, else lowest pending overall
   always_comb begin
      w_any     = 1'b0;
      w_hit_hi  = 1'b0;
      w_sel_hi  = '0;
      w_sel_lo  = '0;
      w_gnt_cnt = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (r_pend[k]) begin
            w_any    = 1'b1;
            w_sel_lo = CW'(k);
            if (CW'(k) > r_last) begin
               w_hit_hi = 1'b1;
               w_sel_hi = CW'(k);
            end
         end
      end
      w_next = w_hit_hi ? w_sel_hi : w_sel_lo;
      for (int k = 0; k < CH; k++) begin
         if (w_next == CW'(k)) w_gnt_cnt = r_cnt[k];
         w_clr[k] = w_grant && (w_next == CW'(k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_any) w_state_nxt = c_ADDR;
         c_ADDR:  w_state_nxt = c_WAIT;
         c_WAIT:  if (bus.rom_ok) w_state_nxt = c_DONE;
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      bus.rom_cs = (r_state != c_IDLE);
      w_grant    = (r_state == c_IDLE) && w_any;
      w_capture  = (r_state == c_WAIT) && bus.rom_ok;
      w_done     = (r_state == c_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt  <= '0;
         r_last <= CW'(CH - 1);
         r_addr <= '0;
         r_data <= 8'h00;
      end else begin
         if (w_grant) begin
            r_gnt  <= w_next;
            r_last <= w_next;
            r_addr <= w_gnt_cnt;
         end
         if (w_capture) r_data <= bus.rom_data;
      end
   end

   // AC coupling: 8'h80 is silence, so the sample is mirrored around it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CH; k++) begin
            r_snd[k]    <= 8'h00;
            r_shadow[k] <= 8'h00;
         end
         r_stb <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            r_stb[k] <= w_done && !w_end && (r_gnt == CW'(k));
            if (w_done && r_gnt == CW'(k)) begin
               r_shadow[k] <= r_data;
               if (!w_end) r_snd[k] <= 8'h80 - r_data;
            end
         end
      end
   end

   always_comb begin
      bus.cpu_dout = 8'h00;
      w_snd        = '0;
      for (int k = 0; k < CH; k++) begin
         w_snd[8*k +: 8] = r_snd[k];
         if (bus.cpu_ch == CW'(k)) bus.cpu_dout = r_shadow[k];
      end
   end

   assign bus.snd      = w_snd;
   assign bus.snd_stb  = r_stb;
   assign bus.rom_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_jtvigil_pcm_multi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_jtvigil_pcm_multi
// Brief  : Directed vector table plus fetch-ordering, blocking, reset and autoplay sequences
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_jtvigil_pcm_multi;
   localparam int CH = 2;
   localparam int AW = 16;
   localparam int CW = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jtvigil_pcm_multi_if #(.CH(CH), .AW(AW), .CW(CW)) bus ();

   jtvigil_pcm_multi #(.CH(CH), .AW(AW), .CW(CW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ROM: data from an array, rom_ok after rom_lat cycles of rom_cs, forced low by rom_hold
   logic [7:0] rom [0:65535];
   logic       rom_hold = 1'b0;
   int         rom_lat  = 0;
   int         cs_age   = 0;
   always @(posedge clk) cs_age <= bus.rom_cs ? cs_age + 1 : 0;
   assign bus.rom_data = rom[bus.rom_addr];
   assign bus.rom_ok   = !rom_hold && (cs_age >= rom_lat);

   int            cs_rises = 0;
   int            stb_cnt [CH] = '{default: 0};
   logic [AW-1:0] last_addr = '0;
   logic          cs_q = 1'b0;
   always @(negedge clk) begin
      if (bus.rom_cs && !cs_q) begin
         cs_rises++;
         last_addr = bus.rom_addr;
      end
      cs_q = bus.rom_cs;
      for (int k = 0; k < CH; k++) if (bus.snd_stb[k]) stb_cnt[k]++;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input int ch, input int rg, input logic [7:0] d);
      @(negedge clk);
      bus.cpu_ch  = CW'(ch);
      bus.cpu_reg = 2'(rg);
      bus.cpu_din = d;
      bus.cpu_wr  = 1'b1;
      repeat (3) @(negedge clk);
      bus.cpu_wr  = 1'b0;
   endtask

   task automatic wait_stb(input int ch, input int base, input string name);
      int n = 0;
      while (stb_cnt[ch] == base && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(n < 100), 32'd1);
   endtask

   task automatic tick_pulse();
      @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
   endtask

   typedef struct {
      int         ch;
      logic [7:0] hi;
      logic [7:0] lo;
      logic [7:0] data;
      logic [15:0] exp_addr;
      logic [7:0] exp_snd;
   } vec_t;

   vec_t vecs [6];
   int   b0, b1, c0, lat;

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 8'(i) & 8'h7F;
      vecs[0] = '{0, 8'h12, 8'h34, 8'h90, 16'h1235, 8'hF0};
      vecs[1] = '{1, 8'hFF, 8'hFF, 8'h01, 16'h0000, 8'h7F};
      vecs[2] = '{0, 8'h00, 8'h7F, 8'h80, 16'h0080, 8'h00};
      vecs[3] = '{1, 8'hAB, 8'hCD, 8'h00, 16'hABCE, 8'h80};
      vecs[4] = '{0, 8'h7F, 8'hFF, 8'h7F, 16'h8000, 8'h01};
      vecs[5] = '{1, 8'h12, 8'hFE, 8'hC3, 16'h12FF, 8'hBD};

      bus.cpu_wr  = 1'b0;
      bus.cpu_rd  = 1'b0;
      bus.cpu_ch  = '0;
      bus.cpu_reg = 2'd0;
      bus.cpu_din = 8'h00;
      bus.tick    = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_rom_cs",  32'(bus.rom_cs),  32'd0);
      check("reset_snd",     32'(bus.snd),     32'd0);
      check("reset_snd_stb", 32'(bus.snd_stb), 32'd0);
      check("reset_dout",    32'(bus.cpu_dout), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         b0 = stb_cnt[vecs[i].ch];
         c0 = cs_rises;
         rom[vecs[i].exp_addr] = vecs[i].data;
         cpu_write(vecs[i].ch, 1, vecs[i].hi);
         cpu_write(vecs[i].ch, 0, vecs[i].lo);
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_load_no_fetch", i), 32'(cs_rises), 32'(c0));
         cpu_write(vecs[i].ch, 2, 8'h00);
         wait_stb(vecs[i].ch, b0, $sformatf("v%0d_stb_timeout", i));
         repeat (5) @(negedge clk);
         check($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
         check($sformatf("v%0d_snd", i), 32'(bus.snd[8*vecs[i].ch +: 8]), 32'(vecs[i].exp_snd));
         check($sformatf("v%0d_one_stb", i), 32'(stb_cnt[vecs[i].ch]), 32'(b0 + 1));
         check($sformatf("v%0d_dout", i), 32'(bus.cpu_dout), 32'(vecs[i].data));
         check($sformatf("v%0d_one_cs", i), 32'(cs_rises), 32'(c0 + 1));
      end

      // Advance-to-strobe latency with rom_ok already high
      @(negedge clk);
      bus.cpu_ch  = 1'b0;
      bus.cpu_reg = 2'd2;
      bus.cpu_wr  = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.snd_stb[0] && lat < 50);
      bus.cpu_wr = 1'b0;
      check("latency_negedges", 32'(lat), 32'd5);
      repeat (5) @(negedge clk);

      // Two channels queued behind a slow ROM: ch0 first, then ch1, two requests
      rom_lat = 5;
      b0 = stb_cnt[0];
      b1 = stb_cnt[1];
      c0 = cs_rises;
      cpu_write(0, 2, 8'h00);
      cpu_write(1, 2, 8'h00);
      wait_stb(0, b0, "order_ch0_timeout");
      check("order_ch1_not_yet", 32'(stb_cnt[1]), 32'(b1));
      wait_stb(1, b1, "order_ch1_timeout");
      repeat (10) @(negedge clk);
      check("order_two_cs", 32'(cs_rises), 32'(c0 + 2));
      check("order_ch0_once", 32'(stb_cnt[0]), 32'(b0 + 1));
      rom_lat = 0;

      // Two ch0 advances while a ch1 fetch holds the port: one fetch at base+2
      cpu_write(0, 1, 8'h20);
      cpu_write(0, 0, 8'h00);
      rom[16'h2002] = 8'h40;
      rom_hold = 1'b1;
      b0 = stb_cnt[0];
      b1 = stb_cnt[1];
      c0 = cs_rises;
      cpu_write(1, 2, 8'h00);
      cpu_write(0, 2, 8'h00);
      cpu_write(0, 2, 8'h00);
      rom_hold = 1'b0;
      wait_stb(1, b1, "block_ch1_timeout");
      wait_stb(0, b0, "block_ch0_timeout");
      repeat (10) @(negedge clk);
      check("block_addr", 32'(last_addr), 32'h2002);
      check("block_snd", 32'(bus.snd[7:0]), 32'h40);
      check("block_one_stb", 32'(stb_cnt[0]), 32'(b0 + 1));
      check("block_two_cs", 32'(cs_rises), 32'(c0 + 2));

      // Reset during WAIT
      rom_hold = 1'b1;
      b0 = stb_cnt[0];
      c0 = cs_rises;
      cpu_write(0, 2, 8'h00);
      check("rst_cs_before", 32'(bus.rom_cs), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_cs_drop", 32'(bus.rom_cs), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rom_hold = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_no_stb", 32'(stb_cnt[0]), 32'(b0));
      check("rst_no_refetch", 32'(cs_rises), 32'(c0 + 1));
      check("rst_snd_clear", 32'(bus.snd), 32'd0);
      b0 = stb_cnt[0];
      cpu_write(0, 2, 8'h00);
      wait_stb(0, b0, "rst_ch0_timeout");
      check("rst_ch0_cnt", 32'(last_addr), 32'h0001);
      b1 = stb_cnt[1];
      cpu_write(1, 2, 8'h00);
      wait_stb(1, b1, "rst_ch1_timeout");
      check("rst_ch1_cnt", 32'(last_addr), 32'h0001);
      repeat (3) @(negedge clk);

`ifdef JTVIGIL_PCM_AUTO_EN
      rom[16'h0101] = 8'h80;
      rom[16'h0102] = 8'h7F;
      rom[16'h0103] = 8'hFF;
      cpu_write(0, 1, 8'h01);
      cpu_write(0, 0, 8'h00);
      cpu_write(0, 3, 8'h01);
      b0 = stb_cnt[0];
      tick_pulse();
      wait_stb(0, b0, "auto1_timeout");
      repeat (2) @(negedge clk);
      check("auto1_snd", 32'(bus.snd[7:0]), 32'h00);
      b0 = stb_cnt[0];
      tick_pulse();
      wait_stb(0, b0, "auto2_timeout");
      repeat (2) @(negedge clk);
      check("auto2_snd", 32'(bus.snd[7:0]), 32'h01);
      b0 = stb_cnt[0];
      c0 = cs_rises;
      tick_pulse();
      repeat (20) @(negedge clk);
      check("auto3_fetched", 32'(cs_rises), 32'(c0 + 1));
      check("auto3_no_stb", 32'(stb_cnt[0]), 32'(b0));
      check("auto3_snd_held", 32'(bus.snd[7:0]), 32'h01);
      check("auto3_dout", 32'(bus.cpu_dout), 32'hFF);
      check("auto3_addr", 32'(last_addr), 32'h0103);
      c0 = cs_rises;
      tick_pulse();
      repeat (10) @(negedge clk);
      check("auto_cleared", 32'(cs_rises), 32'(c0));
`else
      c0 = cs_rises;
      cpu_write(0, 3, 8'h01);
      repeat (3) tick_pulse();
      repeat (10) @(negedge clk);
      check("tick_ignored", 32'(cs_rises), 32'(c0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
